// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake bundle for the multiply/divide unit.
// Request side: in_valid/in_ready, in_op, in_a, in_b, in_tag.
// Response side: out_valid/out_ready, out_result, out_tag.
// master drives requests and accepts results; slave is the unit itself.
interface muldiv_unit_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one iteration per cycle.
// Ports: clk, rst_n (sync, active-low), flush (sync abort),
//        bus (muldiv_unit_if.slave) carrying request and response handshakes.
// Multiplies use shift-add, divides use restoring shift-subtract on
// magnitudes; signs are fixed up on the final iteration edge.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_op;
    logic [WIDTH-1:0]      r_opb;
    logic [2*WIDTH-1:0]    r_acc;
    logic                  r_neg;
    logic                  r_nega;
    logic [WIDTH-1:0]      r_result;
    logic [TAG_WIDTH-1:0]  r_tag;

    // request decode
    logic                  w_sa;
    logic                  w_sb;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [WIDTH-1:0]      w_a_mag;
    logic [WIDTH-1:0]      w_b_mag;
    logic                  w_bz;
    logic                  w_ovf;
    logic                  w_fast;
    logic [WIDTH-1:0]      w_fast_res;

    // iteration datapath
    logic [WIDTH:0]        w_sum;
    logic [WIDTH:0]        w_rsh;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_diff;
    logic [2*WIDTH-1:0]    w_acc_nxt;
    logic [2*WIDTH-1:0]    w_prod;
    logic [WIDTH-1:0]      w_quo;
    logic [WIDTH-1:0]      w_rem;
    logic [WIDTH-1:0]      w_final;

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = r_result;
    assign bus.out_tag    = r_tag;

    // operand signedness per funct3
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        unique case (bus.in_op)
            3'b001: begin w_sa = 1'b1; w_sb = 1'b1; end
            3'b010: begin w_sa = 1'b1; end
            3'b100: begin w_sa = 1'b1; w_sb = 1'b1; end
            3'b110: begin w_sa = 1'b1; w_sb = 1'b1; end
            default: begin end
        endcase
    end

    assign w_a_neg = w_sa & bus.in_a[WIDTH-1];
    assign w_b_neg = w_sb & bus.in_b[WIDTH-1];
    // -MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude
    assign w_a_mag = w_a_neg ? (~bus.in_a + 1'b1) : bus.in_a;
    assign w_b_mag = w_b_neg ? (~bus.in_b + 1'b1) : bus.in_b;

    assign w_bz   = (bus.in_b == '0);
    assign w_ovf  = ~bus.in_op[0] & (bus.in_a == MIN_NEG) & (&bus.in_b);
    assign w_fast = bus.in_op[2] & (w_bz | w_ovf);

    always_comb begin
        if (w_bz) begin
            w_fast_res = bus.in_op[1] ? bus.in_a : '1;
        end else begin
            w_fast_res = bus.in_op[1] ? '0 : bus.in_a;
        end
    end

    // multiply: add multiplicand into the upper half, shift right
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_opb} : '0);

    // divide: remainder (upper) shifted left with next dividend bit;
    // the bit shifted out of the upper half forces a subtract
    assign w_rsh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge   = w_rsh[WIDTH] | (w_rsh[WIDTH-1:0] >= r_opb);
    assign w_diff = w_rsh[WIDTH-1:0] - r_opb;

    always_comb begin
        if (r_op[2]) begin
            if (w_ge) begin
                w_acc_nxt = {w_diff, r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg  ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    assign w_quo  = r_neg  ? (~w_acc_nxt[WIDTH-1:0] + 1'b1)
                           : w_acc_nxt[WIDTH-1:0];
    assign w_rem  = r_nega ? (~w_acc_nxt[2*WIDTH-1:WIDTH] + 1'b1)
                           : w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        unique case (r_op)
            3'b000:  w_final = w_prod[WIDTH-1:0];
            3'b001,
            3'b010,
            3'b011:  w_final = w_prod[2*WIDTH-1:WIDTH];
            3'b100,
            3'b101:  w_final = w_quo;
            default: w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_nega   <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op   <= bus.in_op;
                        r_tag  <= bus.in_tag;
                        r_cnt  <= '0;
                        r_neg  <= w_a_neg ^ w_b_neg;
                        r_nega <= w_a_neg;
                        if (bus.in_op[2]) begin
                            r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opb <= w_b_mag;
                        end else begin
                            r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opb <= w_a_mag;
                        end
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_final;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, multi-cycle RV32M multiply/divide unit for the LX32 execute stage.
- Sits beside the single-cycle ALU and completes all eight M-extension operations.
- Uses a valid/ready handshake on both sides, a pass-through destination tag, and a pipeline flush input.
- Generalises the combinational ALU in two ways: it is sequential, and its operand width is parametrised.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.
- TAG_WIDTH, 5, width of the opaque tag (destination register index) carried from request to response.

Ports:
- clk  input  1  Rising-edge clock; all state updates on this edge.
- rst_n  input  1  Synchronous active-low reset, sampled on the rising edge of clk.
- flush  input  1  Synchronous abort of any in-flight or pending operation.
- in_valid  input  1  Request valid.
- in_ready  output  1  Unit can accept a request.
- in_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  input  WIDTH  rs1 operand (dividend / multiplicand).
- in_b  input  WIDTH  rs2 operand (divisor / multiplier).
- in_tag  input  TAG_WIDTH  Opaque request tag.
- out_valid  output  1  Result valid.
- out_ready  input  1  Consumer accepts the result.
- out_result  output  WIDTH  Result.
- out_tag  output  TAG_WIDTH  Tag of the request that produced out_result.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst_n is synchronous and active-low.
  - While rst_n=0 at a rising edge: state=IDLE, iteration counter=0, out_valid=0, out_result=0, out_tag=0.
  - in_ready is combinational and equals (state==IDLE), so it reads 1 after reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: one iteration per cycle.
  - DONE: out_valid=1.
- Acceptance:
  - A request is accepted on an edge where in_valid && in_ready && !flush.
  - On acceptance, in_a, in_b, in_op and in_tag are captured.
  - Inputs are don't-care after the accepting edge.
- Normal path (all ops without a special case):
  - The accepting edge E0 moves IDLE->BUSY.
  - The unit performs exactly WIDTH iterations on edges E0+1 .. E0+WIDTH:
    - shift-add for the multiplier;
    - restoring shift-subtract for the divider, operating on magnitudes.
  - Edge E0+WIDTH writes the final, sign-corrected result to out_result and moves BUSY->DONE.
  - out_valid is therefore first high in the cycle after E0+WIDTH.
- Fast path:
  - Taken for divide-by-zero and signed overflow.
  - Edge E0 moves IDLE->DONE directly; out_valid is high in the cycle after E0.
- Multiply width rules:
  - The full 2*WIDTH-bit product is formed.
  - MUL returns the low WIDTH bits.
  - MULH: signed x signed, high WIDTH bits.
  - MULHSU: signed a x unsigned b, high WIDTH bits.
  - MULHU: unsigned x unsigned, high WIDTH bits.
- Divide rules:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Divide by zero (b=0):
  - DIV/DIVU return all ones.
  - REM/REMU return a.
- Signed overflow (DIV/REM with a = most-negative value, b = all ones):
  - DIV returns a.
  - REM returns 0.
- DONE and output handshake:
  - out_result and out_tag hold stable while out_valid && !out_ready; back-pressure is indefinite.
  - On out_valid && out_ready, DONE->IDLE.
  - No new request can be accepted in that same cycle (in_ready=0 in DONE). Minimum issue interval is normal latency + 1.
- Flush:
  - Priority below reset, above everything else.
  - Any state moves to IDLE on the next edge, out_valid=0, and the result is discarded.
  - A request presented together with flush is not accepted.
  - out_result and out_tag values after a flush are don't-care, but must not change while out_valid=1.
- Reset during BUSY/DONE: same effect as flush, plus outputs are cleared to 0.
- The iteration counter is $clog2(WIDTH)+1 bits wide and must not wrap before BUSY->DONE.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (-3) -> out_result=0xFFFFFFEB. out_valid is first high exactly 32 cycles after the cycle following acceptance; out_tag echoes in_tag=5'h0A.
- High multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Fast path, each with out_valid one cycle after acceptance:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. out_result/out_tag must stay stable and in_ready=0 throughout. Assert out_ready: IDLE and in_ready=1 on the next cycle, then a back-to-back MUL completes correctly.
- Flush and reset during DIVU:
  - Pulse flush in BUSY iteration 10 -> IDLE next cycle; out_valid never rises for that op.
  - A following request issued together with flush is ignored; the next clean request (MUL 3x4) returns 12.
  - Repeat with rst_n=0 mid-BUSY -> all outputs read 0 after the edge.
